// File: rtl/i2c_slave_fsm.sv
// I2C target: START/STOP decode, 7-bit address match, up to two data bytes each way.
// Optional `I2C_SLAVE_SYNC_EN` adds a 2-flop synchronizer ahead of the scl/sda sample registers.
module i2c_slave_fsm #(
    parameter int                  ADDR_LEN   = 7,
    parameter int                  DATA_LEN   = 8,
    parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'b1010110
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl,
    inout  wire                 sda,
    input  logic [DATA_LEN-1:0] tx_data_1,
    input  logic [DATA_LEN-1:0] tx_data_2,
    output logic [DATA_LEN-1:0] rx_data_1,
    output logic [DATA_LEN-1:0] rx_data_2,
    output logic [1:0]          rx_count,
    output logic                rx_valid,
    output logic                addr_match,
    output logic                busy,
    output logic [3:0]          state_slave
);
    localparam int SH_W  = (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
    localparam int CNT_W = $clog2(SH_W + 2);

    typedef enum logic [3:0] {
        IDLE = 4'd0, ADDR = 4'd1, ADDR_ACK = 4'd2, RX_BYTE = 4'd3,
        RX_ACK = 4'd4, TX_BYTE = 4'd5, TX_ACK = 4'd6, WAIT_STOP = 4'd7
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [SH_W-1:0]     sh, sh_n, sh_in;
    logic [DATA_LEN-1:0] tx_sh, tx_sh_n, tx_buf_1, tx_buf_1_n, tx_buf_2, tx_buf_2_n;
    logic [DATA_LEN-1:0] rx_1_n, rx_2_n;
    logic [1:0]          rx_count_n;
    logic                rw, rw_n, byte2, byte2_n, oe, oe_n, wr, wr_n;
    logic                rx_valid_n, addr_match_n;
    logic                scl_s, sda_s, scl_q, sda_q, scl_p, sda_p;
    logic                rise, fall, start, stop;

`ifdef I2C_SLAVE_SYNC_EN
    logic [1:0] scl_sy, sda_sy;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sy <= 2'b11;
            sda_sy <= 2'b11;
        end else begin
            scl_sy <= {scl_sy[0], scl};
            sda_sy <= {sda_sy[0], sda};
        end
    end
    assign scl_s = scl_sy[1];
    assign sda_s = sda_sy[1];
`else
    assign scl_s = scl;
    assign sda_s = sda;
`endif

    // Bus conditions come only from the registered samples; idle bus reads high.
    assign rise  = scl_q & ~scl_p;
    assign fall  = ~scl_q & scl_p;
    assign start = scl_q & scl_p & sda_p & ~sda_q;
    assign stop  = scl_q & scl_p & ~sda_p & sda_q;
    assign sh_in = {sh[SH_W-2:0], sda_q};

    assign sda         = oe ? 1'b0 : 1'bz;
    assign busy        = (state != IDLE);
    assign state_slave = state;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        sh_n         = sh;
        tx_sh_n      = tx_sh;
        tx_buf_1_n   = tx_buf_1;
        tx_buf_2_n   = tx_buf_2;
        rx_1_n       = rx_data_1;
        rx_2_n       = rx_data_2;
        rx_count_n   = rx_count;
        rw_n         = rw;
        byte2_n      = byte2;
        oe_n         = oe;
        wr_n         = wr;
        rx_valid_n   = 1'b0;
        addr_match_n = 1'b0;
        if (start) begin
            state_n    = ADDR;
            cnt_n      = '0;
            rx_count_n = '0;
            wr_n       = 1'b0;
        end else if (stop) begin
            state_n    = IDLE;
            oe_n       = 1'b0;
            wr_n       = 1'b0;
            rx_valid_n = wr && (rx_count != 2'd0);
        end else begin
            case (state)
                ADDR: if (rise) begin
                    sh_n  = sh_in;
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ADDR_LEN)) begin
                        cnt_n = '0;
                        if (sh_in[ADDR_LEN:1] == SLAVE_ADDR) begin
                            state_n      = ADDR_ACK;
                            addr_match_n = 1'b1;
                            rw_n         = sda_q;
                            wr_n         = ~sda_q;
                            if (sda_q) begin
                                tx_buf_1_n = tx_data_1;
                                tx_buf_2_n = tx_data_2;
                            end
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                // cnt marks whether the ACK low phase has started (first fall seen).
                ADDR_ACK: if (fall) begin
                    if (cnt == '0) begin
                        oe_n  = 1'b1;
                        cnt_n = CNT_W'(1);
                    end else if (rw) begin
                        state_n = TX_BYTE;
                        byte2_n = 1'b0;
                        oe_n    = ~tx_buf_1[DATA_LEN-1];
                        tx_sh_n = tx_buf_1 << 1;
                        cnt_n   = CNT_W'(1);
                    end else begin
                        state_n = RX_BYTE;
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                    end
                end
                RX_BYTE: if (rise) begin
                    sh_n  = sh_in;
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_LEN - 1)) begin
                        state_n = RX_ACK;
                        cnt_n   = '0;
                    end
                end
                RX_ACK: if (fall) begin
                    if (cnt == '0) begin
                        if (rx_count == 2'd2) begin
                            state_n = WAIT_STOP;
                        end else begin
                            oe_n       = 1'b1;
                            cnt_n      = CNT_W'(1);
                            rx_count_n = rx_count + 2'd1;
                            if (rx_count == 2'd0) rx_1_n = sh[DATA_LEN-1:0];
                            else                  rx_2_n = sh[DATA_LEN-1:0];
                        end
                    end else begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = RX_BYTE;
                    end
                end
                TX_BYTE: if (fall) begin
                    if (cnt == CNT_W'(DATA_LEN)) begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = TX_ACK;
                    end else begin
                        oe_n    = ~tx_sh[DATA_LEN-1];
                        tx_sh_n = tx_sh << 1;
                        cnt_n   = cnt + CNT_W'(1);
                    end
                end
                TX_ACK: if (rise) begin
                    if (!sda_q && !byte2) begin
                        state_n = TX_BYTE;
                        byte2_n = 1'b1;
                        tx_sh_n = tx_buf_2;
                        cnt_n   = '0;
                    end else begin
                        state_n = WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            scl_p      <= 1'b1;
            sda_p      <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            tx_sh      <= '0;
            tx_buf_1   <= '0;
            tx_buf_2   <= '0;
            rx_data_1  <= '0;
            rx_data_2  <= '0;
            rx_count   <= '0;
            rw         <= 1'b0;
            byte2      <= 1'b0;
            oe         <= 1'b0;
            wr         <= 1'b0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            scl_q      <= scl_s;
            sda_q      <= sda_s;
            scl_p      <= scl_q;
            sda_p      <= sda_q;
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            tx_sh      <= tx_sh_n;
            tx_buf_1   <= tx_buf_1_n;
            tx_buf_2   <= tx_buf_2_n;
            rx_data_1  <= rx_1_n;
            rx_data_2  <= rx_2_n;
            rx_count   <= rx_count_n;
            rw         <= rw_n;
            byte2      <= byte2_n;
            oe         <= oe_n;
            wr         <= wr_n;
            rx_valid   <= rx_valid_n;
            addr_match <= addr_match_n;
        end
    end
endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Directed bench for i2c_slave_fsm: bit-banged master on scl/sda with pull-up, immediate-assertion checks.
module tb_i2c_slave_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    wire        sda;
    logic [7:0] tx_data_1 = 8'h00, tx_data_2 = 8'h00;
    logic [7:0] rx_data_1, rx_data_2;
    logic [1:0] rx_count;
    logic       rx_valid, addr_match, busy;
    logic [3:0] state_slave;

    int checks = 0, errors = 0;
    int rv_cnt = 0, am_cnt = 0;
    int rv0, am0;
    logic       ack;
    logic [7:0] rd;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid)   rv_cnt <= rv_cnt + 1;
        if (addr_match) am_cnt <= am_cnt + 1;
    end

    i2c_slave_fsm dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
        .tx_data_1(tx_data_1), .tx_data_2(tx_data_2),
        .rx_data_1(rx_data_1), .rx_data_2(rx_data_2), .rx_count(rx_count),
        .rx_valid(rx_valid), .addr_match(addr_match), .busy(busy), .state_slave(state_slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One scl period, entered and left with scl low; returns sda seen mid-high.
    task automatic clk_bit(input logic b, output logic seen);
        m_sda = b;
        repeat (4) @(negedge clk);
        scl = 1'b1;
        repeat (3) @(negedge clk);
        seen = sda;
        repeat (3) @(negedge clk);
        scl = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic start_c;
        m_sda = 1'b1;
        repeat (3) @(negedge clk);
        scl = 1'b1;
        repeat (4) @(negedge clk);
        m_sda = 1'b0;
        repeat (4) @(negedge clk);
        scl = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic stop_c;
        m_sda = 1'b0;
        repeat (3) @(negedge clk);
        scl = 1'b1;
        repeat (4) @(negedge clk);
        m_sda = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, a);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(mack, s);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sda", sda, 1'b1);
        chk("rst_rx1", rx_data_1, 8'h00);
        chk("rst_rx2", rx_data_2, 8'h00);
        chk("rst_cnt", rx_count, 2'd0);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_match", addr_match, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", state_slave, 4'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Two-byte write
        rv0 = rv_cnt; am0 = am_cnt;
        start_c();
        chk("wr_state_addr", state_slave, 4'd1);
        chk("wr_busy", busy, 1'b1);
        write_byte(8'hAC, ack); chk("wr_addr_ack", ack, 1'b0);
        chk("wr_match", am_cnt - am0, 1);
        write_byte(8'hAB, ack); chk("wr_b1_ack", ack, 1'b0);
        write_byte(8'hCD, ack); chk("wr_b2_ack", ack, 1'b0);
        stop_c();
        chk("wr_idle", state_slave, 4'd0);
        chk("wr_rx1", rx_data_1, 8'hAB);
        chk("wr_rx2", rx_data_2, 8'hCD);
        chk("wr_cnt", rx_count, 2'd2);
        chk("wr_valid", rv_cnt - rv0, 1);

        // Read: ACK byte 1, NACK byte 2; bytes must be those latched at address ACK
        rv0 = rv_cnt;
        tx_data_1 = 8'h5A; tx_data_2 = 8'hC3;
        start_c();
        write_byte(8'hAD, ack); chk("rd_addr_ack", ack, 1'b0);
        tx_data_1 = 8'h00; tx_data_2 = 8'h00;
        read_byte(1'b0, rd); chk("rd_b1", rd, 8'h5A);
        read_byte(1'b1, rd); chk("rd_b2", rd, 8'hC3);
        chk("rd_wait_stop", state_slave, 4'd7);
        stop_c();
        chk("rd_idle", state_slave, 4'd0);
        chk("rd_no_valid", rv_cnt - rv0, 0);

        // Wrong address
        am0 = am_cnt;
        start_c();
        write_byte(8'hAE, ack); chk("bad_nack", ack, 1'b1);
        chk("bad_state", state_slave, 4'd7);
        write_byte(8'h00, ack); chk("bad_state_hold", state_slave, 4'd7);
        chk("bad_no_match", am_cnt - am0, 0);
        stop_c();
        chk("bad_idle", state_slave, 4'd0);

        // Three-byte write: third byte refused
        rv0 = rv_cnt;
        start_c();
        write_byte(8'hAC, ack); chk("w3_addr_ack", ack, 1'b0);
        write_byte(8'h11, ack); chk("w3_b1_ack", ack, 1'b0);
        write_byte(8'h22, ack); chk("w3_b2_ack", ack, 1'b0);
        write_byte(8'h33, ack); chk("w3_b3_nack", ack, 1'b1);
        chk("w3_wait_stop", state_slave, 4'd7);
        stop_c();
        chk("w3_rx1", rx_data_1, 8'h11);
        chk("w3_rx2", rx_data_2, 8'h22);
        chk("w3_cnt", rx_count, 2'd2);
        chk("w3_valid", rv_cnt - rv0, 1);

        // One write byte, repeated START, then a read
        rv0 = rv_cnt;
        tx_data_1 = 8'h5A;
        start_c();
        write_byte(8'hAC, ack);
        write_byte(8'h77, ack); chk("rs_b1_ack", ack, 1'b0);
        chk("rs_cnt1", rx_count, 2'd1);
        start_c();
        chk("rs_cnt_clr", rx_count, 2'd0);
        chk("rs_state", state_slave, 4'd1);
        write_byte(8'hAD, ack); chk("rs_addr_ack", ack, 1'b0);
        read_byte(1'b1, rd); chk("rs_rd", rd, 8'h5A);
        chk("rs_wait_stop", state_slave, 4'd7);
        stop_c();
        chk("rs_rx1_kept", rx_data_1, 8'h77);
        chk("rs_no_valid", rv_cnt - rv0, 0);

        // Reset while TX_BYTE is pulling sda low
        tx_data_1 = 8'h00;
        start_c();
        write_byte(8'hAD, ack);
        chk("rt_state_tx", state_slave, 4'd5);
        chk("rt_sda_low", sda, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rt_sda_rel", sda, 1'b1);
        chk("rt_state", state_slave, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        scl = 1'b1;
        repeat (4) @(negedge clk);
        chk("rt_idle", state_slave, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
